// File: rtl/serial_adder_defs_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// helpers that size the bit counter.
package serial_adder_defs;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // The counter keeps at least one bit so a WIDTH=1 build still has one.
  function automatic int cnt_width(input int width);
    return (clog2(width) < 1) ? 1 : clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder walked LSB first over WIDTH
// cycles, with a start/busy/done handshake and registered sum/cout.
module serial_adder_ctrl
  import serial_adder_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last;
  logic             accept;

  full_adder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so the LSB-first result ends up aligned.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_sum;
    end else begin : g_res_wn
      assign res_next = {fa_sum, res[WIDTH-1:1]};
    end
  endgenerate

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          carry <= fa_cout;
          res   <= res_next;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          if (last) begin
            sum   <= res_next;
            cout  <= fa_cout;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at the negedge just after the accepting edge; n counts cycles
  // from there until done is seen (bounded), bcnt counts busy cycles.
  task automatic wait_done(input bit w1, output int n, output int bcnt);
    n = 1;
    bcnt = 0;
    while (!(w1 ? done1 : done8) && n < 40) begin
      if (w1 ? busy1 : busy8) bcnt++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input bit w1, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, output int lat, output int bcnt);
    @(negedge clk);
    if (w1) begin
      start1 = 1'b1; a1 = av[0]; b1 = bv[0]; cin1 = cv;
    end else begin
      start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
    end
    @(negedge clk);
    start1 = 1'b0;
    start8 = 1'b0;
    wait_done(w1, lat, bcnt);
  endtask

  vec_t v8[7];
  vec_t v1[8];

  initial begin
    int lat, bcnt, nd;
    logic exp_d;

    v8[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    v8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    v8[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    v8[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    v8[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    v8[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    v8[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    v1[0] = '{8'h0, 8'h0, 1'b0, 8'h0, 1'b0};
    v1[1] = '{8'h0, 8'h0, 1'b1, 8'h1, 1'b0};
    v1[2] = '{8'h0, 8'h1, 1'b0, 8'h1, 1'b0};
    v1[3] = '{8'h0, 8'h1, 1'b1, 8'h0, 1'b1};
    v1[4] = '{8'h1, 8'h0, 1'b0, 8'h1, 1'b0};
    v1[5] = '{8'h1, 8'h0, 1'b1, 8'h0, 1'b1};
    v1[6] = '{8'h1, 8'h1, 1'b0, 8'h0, 1'b1};
    v1[7] = '{8'h1, 8'h1, 1'b1, 8'h1, 1'b1};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_busy1", busy1, 0);
    check("rst_sum1", {cout1, sum1}, 0);

    // rst and start together: start must not be latched
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk);
    check("rst_wins_busy", busy8, 0);
    rst = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
    check("rst_wins_idle", busy8, 0);

    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, v8[i].a, v8[i].b, v8[i].cin, lat, bcnt);
      check($sformatf("w8_lat_%0d", i), lat, 9);
      check($sformatf("w8_busy_%0d", i), bcnt, 8);
      check($sformatf("w8_sum_%0d", i), sum8, v8[i].sum);
      check($sformatf("w8_cout_%0d", i), cout8, v8[i].cout);
      if (i == 0) begin
        repeat (4) @(negedge clk);
        check("w8_hold_sum", sum8, 8'h8D);
        check("w8_hold_done", done8, 0);
        check("w8_hold_busy", busy8, 0);
      end
    end

    for (int i = 0; i < 8; i++) begin
      run_op(1'b1, v1[i].a, v1[i].b, v1[i].cin, lat, bcnt);
      check($sformatf("w1_lat_%0d", i), lat, 2);
      check($sformatf("w1_busy_%0d", i), bcnt, 1);
      check($sformatf("w1_res_%0d", i), {cout1, sum1}, {v1[i].cout, v1[i].sum[0]});
    end

    // Start during RUN is ignored; start still high in DONE relaunches.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    wait_done(1'b0, lat, bcnt);
    lat = lat + 2;
    check("ign_lat", lat, 9);
    check("ign_sum", sum8, 8'h30);
    check("ign_cout", cout8, 0);
    @(negedge clk);
    start8 = 1'b0;
    check("relaunch_busy", busy8, 1);
    wait_done(1'b0, lat, bcnt);
    check("relaunch_lat", lat, 9);
    check("relaunch_sum", sum8, 8'hFF);
    check("relaunch_cout", cout8, 0);

    // Reset in the middle of RUN clears everything with no done pulse.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_sum", sum8, 0);
    check("midrst_cout", cout8, 0);
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (done8) nd++;
      @(negedge clk);
    end
    check("midrst_no_done", nd, 0);
    run_op(1'b0, 8'h0F, 8'h01, 1'b0, lat, bcnt);
    check("midrst_fresh_lat", lat, 9);
    check("midrst_fresh_sum", sum8, 8'h10);

    // Back-to-back with start held high.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    @(negedge clk);
    for (int n = 1; n <= 27; n++) begin
      exp_d = (n % 9 == 0);
      check($sformatf("b2b_done_%0d", n), done8, exp_d);
      check($sformatf("b2b_busy_%0d", n), busy8, !exp_d);
      if (exp_d) check($sformatf("b2b_sum_%0d", n), sum8, 8'h02);
      @(negedge clk);
    end
    start8 = 1'b0;
    wait_done(1'b0, lat, bcnt);
    check("b2b_drain_lat", lat, 9);
    check("b2b_drain_sum", sum8, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
